sqemux_switch_ctrl: RTL and testbench
=====================================

# sqemux_switch_ctrl

Sequencer for the AP3 SQEMUX clock-select mux. It turns a requested source change (QMUXIN or SQHSCK) into a glitch-free sequence on the mux control pins: gate off, quiesce, flip SELECT, settle, re-enable. It sits in the fabric clock-network wrapper beside each SQEMUX instance. Its SELECT, SEN, DEN and DYNEN outputs connect directly to the mux. SEN toggles only while DEN is 0, which are the conditions under which the mux timing arcs are defined.

## Interface
Parameters:
- QUIESCE_CYCLES, 4: cycles SEN is held low before SELECT flips; must be ≥1.
- SETTLE_CYCLES, 2: cycles after the SELECT flip before SEN rises; must be ≥1.
- CNT_W, 4: counter width; must hold max(QUIESCE_CYCLES, SETTLE_CYCLES)-1.
- RESET_SELECT, 0: SELECT value held during and after reset.

Ports:
- CLK in 1: controller clock.
- RST in 1: reset, asynchronous, active-high.
- EN in 1: master enable; low forces the mux output gated off.
- REQ in 1: switch request; held until ACK.
- REQ_SEL in 1: requested source (0 = QMUXIN, 1 = SQHSCK).
- DYN_MODE in 1: dynamic-mode configuration bit.
- ACK out 1: one-cycle pulse when REQ is accepted.
- DONE out 1: one-cycle pulse when the requested source is live.
- BUSY out 1: high in QUIESCE and SETTLE.
- SELECT out 1: drives the mux SELECT pin.
- SEN out 1: drives the mux SEN pin.
- DEN out 1: drives the mux DEN pin; constant 0.
- DYNEN out 1: DYN_MODE registered through one flop.

## Operation
- All outputs are registered.
- Reset values: state OFF, SELECT=RESET_SELECT, SEN=0, ACK=0, DONE=0, BUSY=0, DEN=0, DYNEN=0, counter=0.
- States: OFF, IDLE, QUIESCE, SETTLE.
- An internal flag `req_pend` marks whether a DONE is owed.

Transitions:
- OFF, EN=1: load counter with SETTLE_CYCLES-1, go to SETTLE, req_pend=0.
- IDLE, REQ=1, REQ_SEL==SELECT: stay in IDLE, ACK=1, DONE=1; SEN unchanged.
- IDLE, REQ=1, REQ_SEL!=SELECT: ACK=1, SEN=0, BUSY=1, latch the target, load counter with QUIESCE_CYCLES-1, go to QUIESCE, req_pend=1.
- QUIESCE: decrement the counter each cycle. At counter 0: SELECT=target, load counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: decrement the counter each cycle. At counter 0: SEN=1, BUSY=0, DONE=req_pend, go to IDLE.
- Any state with EN=0: next edge goes to OFF with SEN=0 and BUSY=0. A pending request is dropped without DONE. SELECT keeps its current value, so an abort in SETTLE keeps the new source.

Request rules:
- REQ is ignored in OFF, QUIESCE and SETTLE. The requester holds REQ until ACK; ACK never fires outside IDLE.
- If EN=0 and REQ=1 arrive in the same cycle, EN wins: no ACK.

Output invariants:
- SELECT changes only while SEN=0.
- DEN is always 0.

## Timing
- Let e0 be the edge at which a differing REQ is sampled in IDLE. In the cycle after e0: ACK=1 and SEN=0.
- SELECT flips at edge e0+QUIESCE_CYCLES.
- SEN rises and DONE pulses at edge e0+QUIESCE_CYCLES+SETTLE_CYCLES.
- SEN is low for QUIESCE_CYCLES+SETTLE_CYCLES cycles; defaults give 4+2 = 6.
- A same-source request gives ACK and DONE one cycle after the sampling edge.
- Back-to-back requests: the earliest next acceptance is the edge after DONE.
- On EN rising from OFF, SEN rises SETTLE_CYCLES edges after the edge that samples EN=1.
- RST assertion clears all state asynchronously at any point in a sequence. After RST falls, the first edge that samples EN=1 starts the OFF→SETTLE path.
- DYNEN lags DYN_MODE by exactly one cycle in all states, including OFF.

## Structure
- Shared include `sqemux_ctrl_defs.vh` holds the 2-bit state encodings: OFF=0, IDLE=1, QUIESCE=2, SETTLE=3.
- One sub-module, `sqemux_ctrl_cnt`: a loadable CNT_W-bit down counter with a `zero` flag, shared by QUIESCE and SETTLE.
- The top level holds the FSM, the SELECT/SEN registers, the target latch and req_pend.

## Test plan
- Reset release with EN=1, defaults: SEN rises 2 edges after EN is first sampled; SELECT=0; no DONE.
- Switch from SELECT=0, REQ_SEL=1, sampled at edge e0: ACK in the cycle after e0, SEN low from e0+1, SELECT=1 at e0+4, SEN=1 with DONE at e0+6, BUSY high for 6 cycles.
- Same-source request (SELECT=1, REQ_SEL=1): ACK and DONE in the same cycle; SEN stays 1; SELECT unchanged.
- REQ held through BUSY with an opposite REQ_SEL queued: no second ACK until the edge after DONE, then a full 6-cycle sequence back to SELECT=0.
- EN dropped at e0+2 during QUIESCE: next edge goes to OFF with SEN=0, SELECT unchanged, no DONE. EN reasserted: SEN rises 2 edges later, no DONE.
- RST pulsed mid-SETTLE: SELECT returns to RESET_SELECT and SEN=0 immediately; the assertion check "SELECT changes only when SEN=0" holds throughout.

Source files
------------

// File: rtl/sqemux_switch_ctrl_pkg.sv
// Shared definitions for the SQEMUX switch sequencer.
// The 2-bit state encodings below are fixed because existing wrapper logic depends on them.
package sqemux_switch_ctrl_pkg;

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_QUIESCE = 2'd2;
  localparam logic [1:0] ST_SETTLE  = 2'd3;

endpackage

// File: rtl/sqemux_switch_ctrl_cnt.sv
// Loadable down counter with a zero flag.
// QUIESCE and SETTLE share this counter.
module sqemux_ctrl_cnt
  import sqemux_switch_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sqemux_switch_ctrl.sv
// Glitch-free switch sequencer for the SQEMUX clock-select mux.
// Sequence: gate SEN off, quiesce, flip SELECT, settle, re-enable SEN.
module sqemux_switch_ctrl
  import sqemux_switch_ctrl_pkg::*;
#(
  parameter int   QUIESCE_CYCLES = 4,
  parameter int   SETTLE_CYCLES  = 2,
  parameter int   CNT_W          = 4,
  parameter logic RESET_SELECT   = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic REQ,
  input  logic REQ_SEL,
  input  logic DYN_MODE,
  output logic ACK,
  output logic DONE,
  output logic BUSY,
  output logic SELECT,
  output logic SEN,
  output logic DEN,
  output logic DYNEN
);

  localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             select_q, select_d;
  logic             sen_q, sen_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             target_q, target_d;
  logic             req_pend_q, req_pend_d;
  logic             dynen_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  sqemux_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // EN low overrides every state; SELECT is deliberately left alone on abort.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    sen_d        = sen_q;
    busy_d       = busy_q;
    target_d     = target_q;
    req_pend_d   = req_pend_q;
    ack_d        = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (!EN) begin
      state_d    = ST_OFF;
      sen_d      = 1'b0;
      busy_d     = 1'b0;
      req_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          cnt_load     = 1'b1;
          cnt_load_val = SETTLE_LOAD;
          busy_d       = 1'b1;
          req_pend_d   = 1'b0;
          state_d      = ST_SETTLE;
        end
        ST_IDLE: begin
          if (REQ) begin
            ack_d = 1'b1;
            if (REQ_SEL == select_q) begin
              done_d = 1'b1;
            end else begin
              sen_d        = 1'b0;
              busy_d       = 1'b1;
              target_d     = REQ_SEL;
              cnt_load     = 1'b1;
              cnt_load_val = QUIESCE_LOAD;
              req_pend_d   = 1'b1;
              state_d      = ST_QUIESCE;
            end
          end
        end
        ST_QUIESCE: begin
          if (cnt_zero) begin
            select_d     = target_q;
            cnt_load     = 1'b1;
            cnt_load_val = SETTLE_LOAD;
            state_d      = ST_SETTLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            sen_d      = 1'b1;
            busy_d     = 1'b0;
            done_d     = req_pend_q;
            req_pend_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_OFF;
      select_q   <= RESET_SELECT;
      sen_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      target_q   <= RESET_SELECT;
      req_pend_q <= 1'b0;
      dynen_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      sen_q      <= sen_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      target_q   <= target_d;
      req_pend_q <= req_pend_d;
      dynen_q    <= DYN_MODE;
    end
  end

  assign ACK    = ack_q;
  assign DONE   = done_q;
  assign BUSY   = busy_q;
  assign SELECT = select_q;
  assign SEN    = sen_q;
  assign DEN    = 1'b0;
  assign DYNEN  = dynen_q;

endmodule

// File: tb/tb_sqemux_switch_ctrl.sv
// Self-checking bench for sqemux_switch_ctrl: directed sequences plus random requests,
// with expectations derived from the edge-relative timeline of each request.
module tb_sqemux_switch_ctrl;

  localparam int Q = 4;
  localparam int S = 2;

  logic CLK = 1'b0;
  logic RST, EN, REQ, REQ_SEL, DYN_MODE;
  logic ACK, DONE, BUSY, SELECT, SEN, DEN, DYNEN;

  int errors = 0;
  int checks = 0;
  int rstCount = 0;
  logic curSel;
  logic dynSampled;

  sqemux_switch_ctrl #(
    .QUIESCE_CYCLES (Q),
    .SETTLE_CYCLES  (S),
    .CNT_W          (4),
    .RESET_SELECT   (1'b0)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .REQ      (REQ),
    .REQ_SEL  (REQ_SEL),
    .DYN_MODE (DYN_MODE),
    .ACK      (ACK),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .SELECT   (SELECT),
    .SEN      (SEN),
    .DEN      (DEN),
    .DYNEN    (DYNEN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge RST) rstCount++;

  // SELECT may only move while SEN was low, except when reset forces it.
  initial begin : selMonitor
    logic prevSel, prevSen;
    int lastRst;
    @(negedge CLK);
    prevSel = SELECT;
    prevSen = SEN;
    lastRst = rstCount;
    forever begin
      @(negedge CLK);
      if (lastRst != rstCount || RST) begin
        lastRst = rstCount;
      end else if (SELECT !== prevSel) begin
        checks++;
        assert (prevSen === 1'b0) else begin
          errors++;
          $error("[TB] FAIL sel_while_sen: observed=%b expected=%b", prevSen, 1'b0);
        end
      end
      prevSel = SELECT;
      prevSen = SEN;
    end
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic req, input logic reqSel);
    EN      = en;
    REQ     = req;
    REQ_SEL = reqSel;
  endtask

  task automatic checkState(input string tag, input logic ack, input logic done,
                            input logic busy, input logic sen, input logic sel);
    checkOutput({tag, ".ack"}, ACK, ack);
    checkOutput({tag, ".done"}, DONE, done);
    checkOutput({tag, ".busy"}, BUSY, busy);
    checkOutput({tag, ".sen"}, SEN, sen);
    checkOutput({tag, ".select"}, SELECT, sel);
  endtask

  task automatic tick();
    dynSampled = DYN_MODE;
    @(posedge CLK);
    #1;
    checkOutput("dynen", DYNEN, dynSampled);
    checkOutput("den", DEN, 1'b0);
    DYN_MODE = 1'($urandom_range(0, 1));
  endtask

  // k counts edges after e0; outputs seen after edge e0+k follow directly from Q and S.
  task automatic switchSeq(input logic toSel, input bit queueNext, input logic nextSel);
    logic fromSel;
    fromSel = curSel;
    applyStimulus(1'b1, 1'b1, toSel);
    for (int k = 0; k <= Q + S; k++) begin
      tick();
      checkState("switch", k == 0, k == Q + S, k < Q + S, k >= Q + S,
                 (k >= Q) ? toSel : fromSel);
      if (k == 0) begin
        if (queueNext) REQ_SEL = nextSel;
        else REQ = 1'b0;
      end
    end
    curSel = toSel;
  endtask

  task automatic sameSeq();
    applyStimulus(1'b1, 1'b1, curSel);
    tick();
    checkState("same", 1'b1, 1'b1, 1'b0, 1'b1, curSel);
    REQ = 1'b0;
    tick();
    checkState("same_after", 1'b0, 1'b0, 1'b0, 1'b1, curSel);
  endtask

  task automatic idleGap(input int n);
    REQ = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      checkState("idle", 1'b0, 1'b0, 1'b0, 1'b1, curSel);
    end
  endtask

  task automatic enableSeq(input string tag);
    for (int k = 0; k <= S; k++) begin
      tick();
      checkState(tag, 1'b0, 1'b0, k < S, k == S, curSel);
    end
  endtask

  initial begin
    RST = 1'b1;
    DYN_MODE = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    curSel = 1'b0;
    #2;
    checkState("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.den", DEN, 1'b0);
    checkOutput("reset.dynen", DYNEN, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    enableSeq("enable");

    switchSeq(1'b1, 1'b0, 1'b0);
    idleGap(1);
    sameSeq();

    switchSeq(1'b0, 1'b1, 1'b1);
    switchSeq(1'b1, 1'b1, 1'b0);
    switchSeq(1'b0, 1'b0, 1'b0);
    idleGap(2);

    // Abort during QUIESCE: EN sampled low at e0+2.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkState("abort_e0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    REQ = 1'b0;
    tick();
    checkState("abort_e1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    EN = 1'b0;
    tick();
    checkState("abort_off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkState("off_req", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    enableSeq("reenable");

    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkState("en_wins", 1'b0, 1'b0, 1'b0, 1'b0, curSel);
    applyStimulus(1'b1, 1'b0, 1'b1);
    enableSeq("en_wins_back");

    // Reset pulse once SELECT has flipped and SETTLE is counting.
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int k = 0; k <= Q; k++) begin
      tick();
      if (k == 0) REQ = 1'b0;
    end
    checkOutput("pre_rst.select", SELECT, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    checkState("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    curSel = 1'b0;
    enableSeq("post_rst");

    repeat (12) begin
      logic t;
      t = 1'($urandom_range(0, 1));
      if (t == curSel) sameSeq();
      else switchSeq(t, 1'b0, 1'b0);
      idleGap($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
